// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: shared prescaled timebase, per-channel synchroniser and
// debouncer, and a registered output running OFF / ON / BLINK / ONESHOT.
module led_blink_ctrl #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned PRESCALE = 100000,
   parameter int unsigned PRE_W    = 17,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   in,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CNT_W-1:0]      half_period,
   input  logic [CNT_W-1:0]      oneshot_len,
   output logic [CHANNELS-1:0]   out,
   output logic                  tick
);

   localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [1:0] MODE_OFF     = 2'b00;
   localparam logic [1:0] MODE_ON      = 2'b01;
   localparam logic [1:0] MODE_BLINK   = 2'b10;
   localparam logic [1:0] MODE_ONESHOT = 2'b11;

   typedef enum logic {OS_IDLE = 1'b0, OS_ACTIVE = 1'b1} os_state_e;

   logic [PRE_W-1:0]    pre_cnt;
   logic                pre_wrap_c;
   logic [CNT_W-1:0]    blink_last_c;
   logic [CHANNELS-1:0] out_d_c;

   // Timebase: tick is high for the single cycle following the terminal count.
   assign pre_wrap_c = (pre_cnt == PRE_W'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         pre_cnt <= pre_wrap_c ? '0 : pre_cnt + PRE_W'(1);
         tick    <= pre_wrap_c;
      end
   end

   // A half-period of 0 behaves as 1.
   assign blink_last_c = (half_period == '0) ? '0 : half_period - CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else        out <= out_d_c;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [1:0]       sync_q;
      logic             acc_q, acc_d;
      logic [DB_W-1:0]  run_q, run_d;
      logic             trig_c;
      logic [1:0]       mode_c, mode_q;
      logic [CNT_W-1:0] bcnt_q, bcnt_d;
      logic             phase_q, phase_d;
      os_state_e        os_q, os_d;
      logic [CNT_W-1:0] rem_q, rem_d;
      logic             out_d;

      assign mode_c     = mode[2*g +: 2];
      assign out_d_c[g] = out_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q  <= '0;
            acc_q   <= 1'b0;
            run_q   <= '0;
            mode_q  <= MODE_OFF;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            os_q    <= OS_IDLE;
            rem_q   <= '0;
         end else begin
            sync_q  <= {sync_q[0], in[g]};
            acc_q   <= acc_d;
            run_q   <= run_d;
            mode_q  <= mode_c;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            os_q    <= os_d;
            rem_q   <= rem_d;
         end
      end

      // Debouncer: trig fires on the tick that accepts a new high level.
      always_comb begin
         acc_d  = acc_q;
         run_d  = run_q;
         trig_c = 1'b0;
         if (tick) begin
            if (sync_q[1] != acc_q) begin
               if (run_q == DB_W'(DEBOUNCE - 1)) begin
                  acc_d  = sync_q[1];
                  run_d  = '0;
                  trig_c = sync_q[1];
               end else begin
                  run_d = run_q + DB_W'(1);
               end
            end else begin
               run_d = '0;
            end
         end
      end

      // Mode datapath and one-shot FSM; any mode change clears all channel state.
      always_comb begin
         bcnt_d  = bcnt_q;
         phase_d = phase_q;
         os_d    = os_q;
         rem_d   = rem_q;
         out_d   = 1'b0;
         if (mode_c != mode_q) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
            os_d    = OS_IDLE;
            rem_d   = '0;
            out_d   = (mode_c == MODE_ON);
         end else begin
            unique case (mode_c)
               MODE_OFF, MODE_ON: begin
                  bcnt_d  = '0;
                  phase_d = 1'b0;
                  os_d    = OS_IDLE;
                  rem_d   = '0;
                  out_d   = (mode_c == MODE_ON);
               end
               MODE_BLINK: begin
                  os_d  = OS_IDLE;
                  rem_d = '0;
                  if (tick) begin
                     if (bcnt_q == blink_last_c) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                     end else begin
                        bcnt_d = bcnt_q + CNT_W'(1);
                     end
                  end
                  out_d = phase_d;
               end
               MODE_ONESHOT: begin
                  bcnt_d  = '0;
                  phase_d = 1'b0;
                  unique case (os_q)
                     OS_IDLE: begin
                        if (trig_c && (oneshot_len != '0)) begin
                           os_d  = OS_ACTIVE;
                           rem_d = oneshot_len;
                        end
                     end
                     OS_ACTIVE: begin
                        if (trig_c && (oneshot_len != '0)) begin
                           rem_d = oneshot_len;
                        end else if (tick) begin
                           if (rem_q == CNT_W'(1)) begin
                              os_d  = OS_IDLE;
                              rem_d = '0;
                           end else begin
                              rem_d = rem_q - CNT_W'(1);
                           end
                        end
                     end
                  endcase
                  out_d = (os_d == OS_ACTIVE);
               end
            endcase
         end
      end
   end

endmodule
